// File: rtl/apb_uart_core_v2_if.sv
// APB slave bundle for apb_uart_core_v2.
// Carries the bus handshake; clk/reset and serial pins stay plain ports.
interface apb_uart_core_v2_if;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_uart_core_v2.sv
// APB UART with TX/RX FIFOs, run-time divisor, parity, sticky errors.
// Define UART_IRQ_EN to add the irq port and the IRQ_EN register.
module apb_uart_core_v2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic       push_ok
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok;

  // a pop frees a slot, so a full FIFO still takes a same-cycle push
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    empty   = cnt_q == '0;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    rdata   = mem_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module apb_uart_core_v2 #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_DEFAULT = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  apb_uart_core_v2_if.slave  apb,
  input  logic               rx,
  output logic               tx
`ifdef UART_IRQ_EN
  ,
  output logic               irq
`endif
);
  localparam logic [15:0] BAUD_RST =
    16'(CLK_FREQ / (BAUD_DEFAULT * OVERSAMPLE));
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] baud_act_q, baud_act_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  stk_q, stk_d;

  tx_state_e   txs_q, txs_d;
  logic [3:0]  tx_tc_q, tx_tc_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_par_q, tx_par_d;
  logic        tx_pen_q, tx_pen_d;
  logic        tx_two_q, tx_two_d;
  logic        tx_stp2_q, tx_stp2_d;
  logic        tx_q, tx_d;

  rx_state_e   rxs_q, rxs_d;
  logic [3:0]  rx_tc_q, rx_tc_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_pen_q, rx_pen_d;
  logic        rx_odd_q, rx_odd_d;
  logic        rx_perr_q, rx_perr_d;
  logic        rx_s1_q, rx_s2_q;

  logic        access, wr, rd;
  logic        a_data, a_stat, a_ctrl, a_baud;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [3:0]  w1c, stk_set;
  logic        baud_wr, both_idle, tick;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_push_ok;
  logic [7:0]  tx_rdata;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_push_ok;
  logic        frame_set, par_set;
  logic        tx_busy;
  logic [15:0] unused_pwdata;

`ifdef UART_IRQ_EN
  logic        a_irq;
  logic [2:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  assign unused_pwdata = apb.PWDATA[31:16];

  apb_uart_core_v2_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (tx_push),
    .wdata   (apb.PWDATA[7:0]),
    .pop     (tx_pop),
    .rdata   (tx_rdata),
    .full    (tx_full),
    .empty   (tx_empty),
    .push_ok (tx_push_ok)
  );

  logic [7:0] rx_rdata;

  apb_uart_core_v2_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push),
    .wdata   (rx_sh_q),
    .pop     (rx_pop),
    .rdata   (rx_rdata),
    .full    (rx_full),
    .empty   (rx_empty),
    .push_ok (rx_push_ok)
  );

  assign tx_busy = txs_q != TX_IDLE;
  assign status  = {23'b0, stk_q, rx_empty, rx_full,
                    tx_empty, tx_full, tx_busy};

  always_comb begin
    access = apb.PSEL & apb.PENABLE & ~pready_q;
    wr     = access & apb.PWRITE;
    rd     = access & ~apb.PWRITE;
    a_data = apb.PADDR == 5'h00;
    a_stat = apb.PADDR == 5'h04;
    a_ctrl = apb.PADDR == 5'h08;
    a_baud = apb.PADDR == 5'h0C;
`ifdef UART_IRQ_EN
    a_irq  = apb.PADDR == 5'h10;
`endif
  end

  always_comb begin
    rdata   = '0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    w1c     = '0;
    ctrl_d  = ctrl_q;
    baud_d  = baud_q;
    baud_wr = 1'b0;
`ifdef UART_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    unique case (1'b1)
      a_data: begin
        tx_push = wr;
        rx_pop  = rd & ~rx_empty;
        rdata   = rx_empty ? '0 : {24'b0, rx_rdata};
      end
      a_stat: begin
        rdata = status;
        if (wr) w1c = apb.PWDATA[8:5];
      end
      a_ctrl: begin
        rdata = {27'b0, ctrl_q};
        if (wr) ctrl_d = apb.PWDATA[4:0];
      end
      a_baud: begin
        rdata = {16'b0, baud_q};
        if (wr) begin
          baud_wr = 1'b1;
          baud_d  = (apb.PWDATA[15:0] == '0) ? 16'd1
                                             : apb.PWDATA[15:0];
        end
      end
`ifdef UART_IRQ_EN
      a_irq: begin
        rdata = {29'b0, irq_en_q};
        if (wr) irq_en_d = apb.PWDATA[2:0];
      end
`endif
      default: ;
    endcase
    pready_d = access;
    prdata_d = rd ? rdata : '0;
  end

  // sticky set beats a same-cycle W1C
  always_comb begin
    stk_set = {tx_push & ~tx_push_ok, par_set,
               frame_set, rx_push & ~rx_push_ok};
    stk_d   = (stk_q & ~w1c) | stk_set;
  end

  // divisor switches only while both FSMs sit between frames
  always_comb begin
    both_idle  = (txs_q == TX_IDLE) && (rxs_q == RX_IDLE);
    baud_act_d = both_idle ? baud_q : baud_act_q;
    tick       = cnt_q >= baud_act_q - 16'd1;
    if (both_idle && (baud_wr || baud_act_q != baud_q))
      cnt_d = '0;
    else if (tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    txs_d     = txs_q;
    tx_tc_d   = tx_tc_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_pen_d  = tx_pen_q;
    tx_two_d  = tx_two_q;
    tx_stp2_d = tx_stp2_q;
    tx_d      = tx_q;
    tx_pop    = 1'b0;
    unique case (txs_q)
      TX_IDLE: begin
        if (tick && ctrl_q[0] && !tx_empty) begin
          tx_pop   = 1'b1;
          txs_d    = TX_START;
          tx_sh_d  = tx_rdata;
          tx_par_d = ^tx_rdata ^ ctrl_q[3];
          tx_pen_d = ctrl_q[2];
          tx_two_d = ctrl_q[4];
          tx_tc_d  = '0;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == LAST) begin
            txs_d    = TX_DATA;
            tx_bit_d = '0;
            tx_d     = tx_sh_q[0];
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == LAST) begin
            if (tx_bit_q == 3'd7) begin
              if (tx_pen_q) begin
                txs_d = TX_PAR;
                tx_d  = tx_par_q;
              end else begin
                txs_d     = TX_STOP;
                tx_stp2_d = 1'b0;
                tx_d      = 1'b1;
              end
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              tx_d     = tx_sh_q[1];
            end
          end
        end
      end
      TX_PAR: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == LAST) begin
            txs_d     = TX_STOP;
            tx_stp2_d = 1'b0;
            tx_d      = 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + 4'd1;
          if (tx_tc_q == LAST) begin
            if (tx_two_q && !tx_stp2_q) tx_stp2_d = 1'b1;
            else txs_d = TX_IDLE;
          end
        end
      end
      default: txs_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rxs_d     = rxs_q;
    rx_tc_d   = rx_tc_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_pen_d  = rx_pen_q;
    rx_odd_d  = rx_odd_q;
    rx_perr_d = rx_perr_q;
    rx_push   = 1'b0;
    frame_set = 1'b0;
    par_set   = 1'b0;
    unique case (rxs_q)
      RX_IDLE: begin
        if (tick && ctrl_q[1] && !rx_s2_q) begin
          rxs_d     = RX_START;
          rx_tc_d   = '0;
          rx_pen_d  = ctrl_q[2];
          rx_odd_d  = ctrl_q[3];
          rx_perr_d = 1'b0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == MID) begin
            rx_tc_d  = '0;
            rx_bit_d = '0;
            rxs_d    = rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == LAST) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7)
              rxs_d = rx_pen_q ? RX_PAR : RX_STOP;
          end
        end
      end
      RX_PAR: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == LAST) begin
            rx_perr_d = rx_s2_q ^ (^rx_sh_q) ^ rx_odd_q;
            rxs_d     = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == LAST) begin
            rx_push   = 1'b1;
            frame_set = ~rx_s2_q;
            par_set   = rx_perr_q;
            rxs_d     = RX_IDLE;
          end
        end
      end
      default: rxs_d = RX_IDLE;
    endcase
  end

`ifdef UART_IRQ_EN
  always_comb begin
    irq_d = |(irq_en_q & {|stk_q, tx_empty, ~rx_empty});
  end
  assign irq = irq_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      ctrl_q     <= 5'b00011;
      baud_q     <= BAUD_RST;
      baud_act_q <= BAUD_RST;
      cnt_q      <= '0;
      stk_q      <= '0;
      txs_q      <= TX_IDLE;
      tx_tc_q    <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_stp2_q  <= 1'b0;
      tx_q       <= 1'b1;
      rxs_q      <= RX_IDLE;
      rx_tc_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
`ifdef UART_IRQ_EN
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      baud_act_q <= baud_act_d;
      cnt_q      <= cnt_d;
      stk_q      <= stk_d;
      txs_q      <= txs_d;
      tx_tc_q    <= tx_tc_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_two_q   <= tx_two_d;
      tx_stp2_q  <= tx_stp2_d;
      tx_q       <= tx_d;
      rxs_q      <= rxs_d;
      rx_tc_q    <= rx_tc_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_perr_q  <= rx_perr_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
`ifdef UART_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign apb.PREADY = pready_q;
  assign apb.PRDATA = prdata_q;
  assign tx         = tx_q;
endmodule
